// File: rtl/router_mesh_param.sv
// Parametrised single-flit mesh router: per-input FIFOs, XY dimension-order
// routing, per-output round-robin arbitration and registered outputs.
module router_mesh_param #(
  parameter int         DATA_WIDTH = 16,
  parameter int         FIFO_DEPTH = 4,
  parameter int         MESH_X     = 4,
  parameter int         MESH_Y     = 2,
  parameter int         ROUTER_X   = 0,
  parameter int         ROUTER_Y   = 0,
  parameter logic [4:0] PORT_EN    = 5'b11111
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [5*DATA_WIDTH-1:0] data_in,
  input  logic [4:0]              valid_in,
  output logic [4:0]              full_out,
  output logic [5*DATA_WIDTH-1:0] data_out,
  output logic [4:0]              valid_out,
  input  logic [4:0]              full_in,
  output logic                    drop_out
);
  // Handshake: an input flit is accepted on a rising edge when valid_in[p] is
  // high and full_out[p] is low; an output flit is presented for exactly one
  // cycle on valid_out[o] and is never retracted once registered.

  localparam int NP = 5;
  localparam int XW = (MESH_X > 1) ? $clog2(MESH_X) : 1;
  localparam int YW = (MESH_Y > 1) ? $clog2(MESH_Y) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [2:0] P_LOCAL = 3'd0;
  localparam logic [2:0] P_EAST  = 3'd1;
  localparam logic [2:0] P_WEST  = 3'd2;
  localparam logic [2:0] P_NORTH = 3'd3;
  localparam logic [2:0] P_SOUTH = 3'd4;

  // One extra bit so MESH_X == 2**XW still compares correctly.
  localparam logic [XW:0]   MX    = (XW+1)'(MESH_X);
  localparam logic [XW:0]   RX    = (XW+1)'(ROUTER_X);
  localparam logic [YW:0]   MY    = (YW+1)'(MESH_Y);
  localparam logic [YW:0]   RY    = (YW+1)'(ROUTER_Y);
  localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q    [NP][FIFO_DEPTH];
  logic [AW-1:0]         rd_ptr_q [NP];
  logic [AW-1:0]         wr_ptr_q [NP];
  logic [CW-1:0]         cnt_q    [NP];
  logic [CW-1:0]         cnt_d    [NP];
  logic [NP-1:0]         full_q, full_d;
  logic [2:0]            rr_q     [NP];
  logic [DATA_WIDTH-1:0] dout_q   [NP];
  logic [NP-1:0]         vout_q;
  logic                  drop_q;

  logic [DATA_WIDTH-1:0] head     [NP];
  logic [2:0]            route    [NP];
  logic [NP-1:0]         nonempty, routable, wr_en, pop, drop_pop;
  logic [NP-1:0]         req      [NP];
  logic [NP-1:0]         gnt_v;
  logic [2:0]            gnt_idx  [NP];

  function automatic logic [2:0] add_mod5(input logic [2:0] a, input logic [2:0] b);
    logic [3:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 4'd5) s = s - 4'd5;
    return s[2:0];
  endfunction

  // Returns {routable, port} for a destination address.
  function automatic logic [3:0] route_of(input logic [XW+YW-1:0] addr);
    logic [XW:0] dx;
    logic [YW:0] dy;
    logic [2:0]  port;
    dx = {1'b0, addr[XW-1:0]};
    dy = {1'b0, addr[XW+YW-1:XW]};
    if (dx > RX)      port = P_EAST;
    else if (dx < RX) port = P_WEST;
    else if (dy > RY) port = P_NORTH;
    else if (dy < RY) port = P_SOUTH;
    else              port = P_LOCAL;
    return {(dx < MX) && (dy < MY) && PORT_EN[port], port};
  endfunction

  always_comb begin
    for (int i = 0; i < NP; i++) begin
      head[i]     = mem_q[i][rd_ptr_q[i]];
      nonempty[i] = (cnt_q[i] != '0);
      {routable[i], route[i]} = route_of(head[i][XW+YW-1:0]);
      wr_en[i]    = valid_in[i] & ~full_q[i] & PORT_EN[i];
      drop_pop[i] = nonempty[i] & ~routable[i];
    end
  end

  always_comb begin
    for (int o = 0; o < NP; o++) begin
      for (int i = 0; i < NP; i++) begin
        req[o][i] = nonempty[i] & routable[i] & (route[i] == 3'(o));
      end
    end
  end

  // Round-robin search from rr_q[o], wrapping 4 -> 0; first requester wins.
  always_comb begin
    logic [2:0] cand;
    cand = '0;
    for (int o = 0; o < NP; o++) begin
      gnt_v[o]   = 1'b0;
      gnt_idx[o] = '0;
      if (PORT_EN[o] && !full_in[o]) begin
        for (int k = 0; k < NP; k++) begin
          cand = add_mod5(rr_q[o], 3'(k));
          if (!gnt_v[o] && req[o][cand]) begin
            gnt_v[o]   = 1'b1;
            gnt_idx[o] = cand;
          end
        end
      end
    end
  end

  always_comb begin
    pop = drop_pop;
    for (int o = 0; o < NP; o++) begin
      if (gnt_v[o]) pop[gnt_idx[o]] = 1'b1;
    end
    for (int i = 0; i < NP; i++) begin
      cnt_d[i]  = cnt_q[i] + CW'(wr_en[i]) - CW'(pop[i]);
      full_d[i] = ~PORT_EN[i] | (cnt_d[i] == DEPTH);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NP; i++) begin
      if (wr_en[i]) mem_q[i][wr_ptr_q[i]] <= data_in[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NP; i++) begin
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
        rr_q[i]     <= '0;
        dout_q[i]   <= '0;
      end
      full_q <= ~PORT_EN;
      vout_q <= '0;
      drop_q <= 1'b0;
    end else begin
      for (int i = 0; i < NP; i++) begin
        if (wr_en[i]) wr_ptr_q[i] <= wr_ptr_q[i] + AW'(1);
        if (pop[i])   rd_ptr_q[i] <= rd_ptr_q[i] + AW'(1);
        cnt_q[i] <= cnt_d[i];
      end
      for (int o = 0; o < NP; o++) begin
        if (gnt_v[o]) begin
          dout_q[o] <= head[gnt_idx[o]];
          rr_q[o]   <= add_mod5(gnt_idx[o], 3'd1);
        end
      end
      full_q <= full_d;
      vout_q <= gnt_v;
      drop_q <= |drop_pop;
    end
  end

  for (genvar o = 0; o < NP; o++) begin : g_out
    assign data_out[o*DATA_WIDTH +: DATA_WIDTH] = dout_q[o];
  end

  assign valid_out = vout_q;
  assign full_out  = full_q;
  assign drop_out  = drop_q;

endmodule

// File: tb/tb_router_mesh_param.sv
// Bench for router_mesh_param: a cycle table on a full interior-style router
// plus hand sequences for disabled ports, a depth-2 FIFO and async reset.
module tb_router_mesh_param;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [5*DW-1:0] din1, dout1, din2, dout2, din3, dout3;
  logic [4:0]      vin1, fin1, fout1, vout1;
  logic [4:0]      vin2, fin2, fout2, vout2;
  logic [4:0]      vin3, fin3, fout3, vout3;
  logic            drop1, drop2, drop3;

  router_mesh_param #(.ROUTER_X(1), .ROUTER_Y(0)) dut1 (
    .clk(clk), .rst(rst), .data_in(din1), .valid_in(vin1), .full_out(fout1),
    .data_out(dout1), .valid_out(vout1), .full_in(fin1), .drop_out(drop1));

  router_mesh_param #(.ROUTER_X(1), .ROUTER_Y(0), .PORT_EN(5'b10111)) dut2 (
    .clk(clk), .rst(rst), .data_in(din2), .valid_in(vin2), .full_out(fout2),
    .data_out(dout2), .valid_out(vout2), .full_in(fin2), .drop_out(drop2));

  router_mesh_param #(.ROUTER_X(1), .ROUTER_Y(0), .FIFO_DEPTH(2)) dut3 (
    .clk(clk), .rst(rst), .data_in(din3), .valid_in(vin3), .full_out(fout3),
    .data_out(dout3), .valid_out(vout3), .full_in(fin3), .drop_out(drop3));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  vin;
    logic [15:0] dl;
    logic [15:0] dw;
    logic [4:0]  fin;
    logic [4:0]  ev;
    logic [15:0] ed;
    logic [4:0]  ef;
  } vec_t;

  vec_t vt[26];
  logic [15:0] exp_q[$];

  function automatic vec_t mk(input logic [4:0] vin, input logic [15:0] dl, input logic [15:0] dw,
                              input logic [4:0] fin, input logic [4:0] ev, input logic [15:0] ed,
                              input logic [4:0] ef);
    vec_t v;
    v.vin = vin; v.dl = dl; v.dw = dw; v.fin = fin; v.ev = ev; v.ed = ed; v.ef = ef;
    return v;
  endfunction

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int lo, input int hi);
    for (int k = lo; k <= hi; k++) begin
      vin1 = vt[k].vin;
      fin1 = vt[k].fin;
      din1 = '0;
      din1[0*DW +: DW] = vt[k].dl;
      din1[2*DW +: DW] = vt[k].dw;
      @(negedge clk);
      check($sformatf("vec%0d valid_out", k), 80'(vout1), 80'(vt[k].ev));
      for (int o = 0; o < 5; o++) begin
        if (vt[k].ev[o]) check($sformatf("vec%0d data_out[%0d]", k, o), 80'(dout1[o*DW +: DW]), 80'(vt[k].ed));
      end
      check($sformatf("vec%0d full_out", k), 80'(fout1), 80'(vt[k].ef));
      check($sformatf("vec%0d drop_out", k), 80'(drop1), 80'(1'b0));
      next_cycle();
    end
  endtask

  initial begin
    int drops;
    int first_drop;

    // zero-load: 0A05 -> (1,1) -> NORTH
    vt[0]  = mk(5'b00001, 16'h0A05, 16'h0000, 5'b00000, 5'b00000, 16'h0000, 5'b00000);
    vt[1]  = mk(5'b00000, 16'h0000, 16'h0000, 5'b00000, 5'b00000, 16'h0000, 5'b00000);
    vt[2]  = mk(5'b00000, 16'h0000, 16'h0000, 5'b00000, 5'b01000, 16'h0A05, 5'b00000);
    vt[3]  = mk(5'b00000, 16'h0000, 16'h0000, 5'b00000, 5'b00000, 16'h0000, 5'b00000);
    // round-robin: LOCAL and WEST both to dst 3 (EAST)
    vt[4]  = mk(5'b00101, 16'hA003, 16'hB003, 5'b00000, 5'b00000, 16'h0000, 5'b00000);
    vt[5]  = mk(5'b00101, 16'hA103, 16'hB103, 5'b00000, 5'b00000, 16'h0000, 5'b00000);
    vt[6]  = mk(5'b00101, 16'hA203, 16'hB203, 5'b00000, 5'b00010, 16'hA003, 5'b00000);
    vt[7]  = mk(5'b00000, 16'h0000, 16'h0000, 5'b00000, 5'b00010, 16'hB003, 5'b00000);
    vt[8]  = mk(5'b00000, 16'h0000, 16'h0000, 5'b00000, 5'b00010, 16'hA103, 5'b00000);
    vt[9]  = mk(5'b00000, 16'h0000, 16'h0000, 5'b00000, 5'b00010, 16'hB103, 5'b00000);
    vt[10] = mk(5'b00000, 16'h0000, 16'h0000, 5'b00000, 5'b00010, 16'hA203, 5'b00000);
    vt[11] = mk(5'b00000, 16'h0000, 16'h0000, 5'b00000, 5'b00010, 16'hB203, 5'b00000);
    vt[12] = mk(5'b00000, 16'h0000, 16'h0000, 5'b00000, 5'b00000, 16'h0000, 5'b00000);
    // backpressure: EAST full, LOCAL sends five flits to dst 2
    vt[13] = mk(5'b00001, 16'hA802, 16'h0000, 5'b00010, 5'b00000, 16'h0000, 5'b00000);
    vt[14] = mk(5'b00001, 16'hA902, 16'h0000, 5'b00010, 5'b00000, 16'h0000, 5'b00000);
    vt[15] = mk(5'b00001, 16'hAA02, 16'h0000, 5'b00010, 5'b00000, 16'h0000, 5'b00000);
    vt[16] = mk(5'b00001, 16'hAB02, 16'h0000, 5'b00010, 5'b00000, 16'h0000, 5'b00000);
    vt[17] = mk(5'b00001, 16'hAC02, 16'h0000, 5'b00010, 5'b00000, 16'h0000, 5'b00001);
    vt[18] = mk(5'b00000, 16'h0000, 16'h0000, 5'b00010, 5'b00000, 16'h0000, 5'b00001);
    vt[19] = mk(5'b00000, 16'h0000, 16'h0000, 5'b00000, 5'b00000, 16'h0000, 5'b00001);
    vt[20] = mk(5'b00000, 16'h0000, 16'h0000, 5'b00000, 5'b00010, 16'hA802, 5'b00000);
    vt[21] = mk(5'b00000, 16'h0000, 16'h0000, 5'b00000, 5'b00010, 16'hA902, 5'b00000);
    vt[22] = mk(5'b00000, 16'h0000, 16'h0000, 5'b00000, 5'b00010, 16'hAA02, 5'b00000);
    vt[23] = mk(5'b00000, 16'h0000, 16'h0000, 5'b00000, 5'b00010, 16'hAB02, 5'b00000);
    vt[24] = mk(5'b00000, 16'h0000, 16'h0000, 5'b00000, 5'b00000, 16'h0000, 5'b00000);
    vt[25] = mk(5'b00000, 16'h0000, 16'h0000, 5'b00000, 5'b00000, 16'h0000, 5'b00000);

    // clock/reset
    rst = 1'b0;
    din1 = '0; vin1 = '0; fin1 = '0;
    din2 = '0; vin2 = '0; fin2 = '0;
    din3 = '0; vin3 = '0; fin3 = 5'b00010;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset valid_out", 80'(vout1), 80'(5'b00000));
    check("reset data_out", dout1, 80'(0));
    check("reset full_out", 80'(fout1), 80'(5'b00000));
    check("reset drop_out", 80'(drop1), 80'(1'b0));
    check("reset full_out disabled", 80'(fout2), 80'(5'b01000));
    check("reset full_out depth2", 80'(fout3), 80'(5'b00000));
    rst = 1'b0;
    next_cycle();

    run_vec(0, 12);
    check("rr east after contention", 80'(dut1.rr_q[1]), 80'(3'd3));
    run_vec(13, 25);

    // disabled NORTH: LOCAL flit to dst 5 is dropped; NORTH input ignored
    vin2 = 5'b01001;
    din2[0*DW +: DW] = 16'h0C05;
    din2[3*DW +: DW] = 16'h0001;
    drops = 0;
    first_drop = -1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check($sformatf("disabled valid_out c%0d", c), 80'(vout2), 80'(5'b00000));
      if (drop2) begin
        drops++;
        if (first_drop < 0) first_drop = c;
      end
      next_cycle();
      vin2 = '0;
    end
    check("disabled drop count", 80'(drops), 80'(1));
    check("disabled drop cycle", 80'(first_drop), 80'(2));
    check("disabled full_out", 80'(fout2), 80'(5'b01000));
    check("disabled fifo empty", 80'(dut2.cnt_q[0]), 80'(0));

    // depth-2 FIFO: pop and held write in the same cycle while full
    exp_q.push_back(16'hE102);
    exp_q.push_back(16'hE202);
    exp_q.push_back(16'hE302);
    for (int c = 0; c < 8; c++) begin
      case (c)
        0: begin vin3 = 5'b00001; din3[0*DW +: DW] = 16'hE102; end
        1: begin vin3 = 5'b00001; din3[0*DW +: DW] = 16'hE202; end
        2: begin vin3 = 5'b00001; din3[0*DW +: DW] = 16'hE302; fin3 = '0; end
        3: begin vin3 = 5'b00001; din3[0*DW +: DW] = 16'hE302; end
        default: vin3 = '0;
      endcase
      @(negedge clk);
      if (c == 2) check("depth2 full before pop", 80'(fout3[0]), 80'(1'b1));
      if (c == 3) check("depth2 full after pop", 80'(fout3[0]), 80'(1'b0));
      check($sformatf("depth2 count bound c%0d", c), 80'(dut3.cnt_q[0] <= 2'd2), 80'(1'b1));
      if (vout3[1]) begin
        if (exp_q.size() == 0) check($sformatf("depth2 extra flit c%0d", c), 80'(vout3[1]), 80'(1'b0));
        else check($sformatf("depth2 data c%0d", c), 80'(dout3[1*DW +: DW]), 80'(exp_q.pop_front()));
      end
      next_cycle();
    end
    check("depth2 flits outstanding", 80'(exp_q.size()), 80'(0));

    // async reset mid-stream: LOCAL fills behind blocked EAST, WEST streams NORTH
    fin1 = 5'b00010;
    vin1 = 5'b00101;
    din1 = '0;
    din1[2*DW +: DW] = 16'h7005;
    for (int c = 0; c < 4; c++) begin
      din1[0*DW +: DW] = 16'hF002 + 16'(c << 8);
      next_cycle();
    end
    @(negedge clk);
    check("pre-reset full_out[0]", 80'(fout1[0]), 80'(1'b1));
    check("pre-reset valid_out[3]", 80'(vout1[3]), 80'(1'b1));
    #2 rst = 1'b1;
    #1;
    check("async reset valid_out", 80'(vout1), 80'(5'b00000));
    check("async reset full_out", 80'(fout1), 80'(5'b00000));
    check("async reset drop_out", 80'(drop1), 80'(1'b0));
    vin1 = '0;
    fin1 = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    next_cycle();
    // rr restarted at 0: LOCAL must beat NORTH to EAST
    vin1 = 5'b01001;
    din1 = '0;
    din1[0*DW +: DW] = 16'hC003;
    din1[3*DW +: DW] = 16'hD003;
    next_cycle();
    vin1 = '0;
    @(negedge clk);
    check("post-reset idle valid_out", 80'(vout1), 80'(5'b00000));
    next_cycle();
    @(negedge clk);
    check("post-reset first valid_out", 80'(vout1), 80'(5'b00010));
    check("post-reset first data", 80'(dout1[1*DW +: DW]), 80'(16'hC003));
    next_cycle();
    @(negedge clk);
    check("post-reset second valid_out", 80'(vout1), 80'(5'b00010));
    check("post-reset second data", 80'(dout1[1*DW +: DW]), 80'(16'hD003));
    next_cycle();
    @(negedge clk);
    check("post-reset drained", 80'(vout1), 80'(5'b00000));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/router_mesh_param.md
Name: router_mesh_param

Overview:
- Parametrised single-flit mesh router. Next generation of the fixed 3-port border router.
- Provides up to 5 ports (LOCAL, EAST, WEST, NORTH, SOUTH). Edge ports are removed via the PORT_EN mask, so one module serves corner, border and interior tiles of any MESH_X x MESH_Y mesh.
- Internals: per-input FIFO, XY dimension-order routing, per-output round-robin arbitration, full-based backpressure, registered outputs.

Parameters:
- DATA_WIDTH, 16: flit width in bits.
- FIFO_DEPTH, 4: input FIFO entries per port. Power of two, >=2.
- MESH_X, 4: mesh columns.
- MESH_Y, 2: mesh rows.
- ROUTER_X, 0: this router's column.
- ROUTER_Y, 0: this router's row.
- PORT_EN, 5'b11111: port enable mask. Bit 0 LOCAL, 1 EAST (x+1), 2 WEST (x-1), 3 NORTH (y+1), 4 SOUTH (y-1).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- data_in  in  5*DATA_WIDTH  input flits; port p occupies slice [p*DATA_WIDTH +: DATA_WIDTH]
- valid_in  in  5  input flit valid, one bit per port
- full_out  out  5  input FIFO full, returned to upstream sender
- data_out  out  5*DATA_WIDTH  registered output flits
- valid_out  out  5  output valid, one-cycle pulse per flit
- full_in  in  5  downstream full; a grant is blocked while set
- drop_out  out  1  one-cycle pulse when any flit is discarded as unroutable

Behaviour:
- Address field
  - XW = max(1, clog2(MESH_X)), YW = max(1, clog2(MESH_Y)).
  - dst_x = flit[XW-1:0], dst_y = flit[XW+YW-1:XW]. Default config gives address = y*4+x in flit[2:0].
- Reset (rst high, asynchronous)
  - All FIFOs empty; all read/write pointers and counts 0.
  - All round-robin pointers 0.
  - data_out=0, valid_out=0, drop_out=0.
  - full_out=0 for enabled ports, 1 for disabled ports.
- Input FIFO
  - Write when valid_in[p] & !full_out[p].
  - full_out[p] = (count==FIFO_DEPTH), driven from registers.
  - valid_in while full: flit ignored, no overwrite, no error flag.
  - Simultaneous read and write: count unchanged. While full, the write stays blocked even if a read occurs that cycle.
- Disabled port p
  - valid_in[p] ignored; full_out[p]=1; valid_out[p] and data_out[p] held 0.
  - full_in[p] is don't-care.
- Route compute (combinational on FIFO head)
  - dst_x>ROUTER_X -> EAST; dst_x<ROUTER_X -> WEST.
  - Otherwise dst_y>ROUTER_Y -> NORTH; dst_y<ROUTER_Y -> SOUTH.
  - Otherwise -> LOCAL. LOCAL-to-LOCAL is legal.
- Unroutable flit
  - Applies when dst_x>=MESH_X, dst_y>=MESH_Y, or the computed port is disabled.
  - Flit is popped the next cycle with no output; drop_out pulses 1 cycle. Not blocked by full_in.
  - Multiple drops in one cycle give a single pulse.
- Arbitration, per output o
  - Requesters: non-empty inputs whose head routes to o.
  - Grant only if full_in[o]==0 and PORT_EN[o].
  - Round-robin search starts at rr[o] and wraps 4->0. On a grant, rr[o] = granted index+1 mod 5. rr[o] is unchanged with no grant.
  - Each input has one destination, so it wins at most one output per cycle.
- Datapath
  - Granted input pops its FIFO in the same cycle.
  - data_out[o]/valid_out[o] are registered on the next edge.
  - valid_out[o]=0 in any cycle following no grant; data_out holds its last value.
- Latency and throughput
  - Zero-load: flit written at edge t becomes head after t; valid_out asserted after edge t+1, i.e. 2 cycles.
  - Throughput: 1 flit/cycle per output.
- full_in timing
  - Sampled in the grant cycle. A flit already registered is delivered regardless.
  - Downstream must assert full with at least one entry of slack.
- Ordering: FIFO order is preserved per input-to-output pair.
- Reset mid-transfer: all in-flight flits are lost; no partial outputs after rst rises.

Test Plan:
- Zero-load routing. Default config, ROUTER_X=1, ROUTER_Y=0. LOCAL injects 16'h0A05 (dst x=1,y=1) -> valid_out[3] (NORTH) high for 1 cycle, 2 cycles after injection, data_out NORTH slice = 16'h0A05; no other valid_out.
- Round-robin contention. LOCAL and WEST each inject 3 flits to dst 3 in the same cycles.
  - EAST emits in order L0,W0,L1,W1,L2,W2 on consecutive cycles.
  - rr[EAST] ends at 3.
- Backpressure. full_in[1]=1; LOCAL sends 5 flits to dst 2 on consecutive cycles.
  - 4 accepted; full_out[0]=1 after the 4th; 5th ignored.
  - Release full_in -> 4 flits out on EAST in order, one per cycle; full_out[0] falls the cycle after the first pop.
- Disabled port. PORT_EN=5'b10111 (NORTH off); LOCAL injects dst 5 -> drop_out pulses once, no valid_out, FIFO empties. Also check full_out[3]=1 and valid_in[3] ignored.
- Simultaneous read/write at full. FIFO_DEPTH=2, full FIFO popped while valid_in held -> write blocked that cycle, accepted the next cycle, count never exceeds 2.
- Async reset. Assert rst mid-stream, between clock edges -> valid_out, full_out (enabled ports) and drop_out are 0 immediately. After release, the first injected flit appears 2 cycles later and rr restarts at input 0.
